// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, FSM state enum and defaults for the multiplier feeder
package mul_pkg;

  localparam int OPW            = 8;
  localparam int RESW           = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPT,
    ST_OUT
  } state_t;

  // An operand pair is stored as {a, b}
  function automatic logic has_zero_operand(input logic [2*OPW-1:0] pair);
    return (pair[2*OPW-1:OPW] == '0) || (pair[OPW-1:0] == '0);
  endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// rtl/mul_operand_fifo.sv - registered operand-pair FIFO, no fall-through
module mul_operand_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [2*OPW-1:0]   push_data,
  input  logic               pop,
  output logic [2*OPW-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [2*OPW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mul_feeder.sv
// rtl/mul_feeder.sv - queues operand pairs and sequences an iterative multiplier
// Optional zero-operand bypass: MUL_FEEDER_ZERO_BYPASS_EN
module mul_feeder
  import mul_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [OPW-1:0]              in_a,
  input  logic [OPW-1:0]              in_b,
  output logic                        in_ready,
  output logic                        mul_load,
  output logic [OPW-1:0]              mul_a,
  output logic [OPW-1:0]              mul_b,
  input  logic [RESW-1:0]             mul_result,
  output logic                        out_valid,
  output logic [RESW-1:0]             out_data,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  state_t           state;
  state_t           state_nxt;
  logic             pop;
  logic             full;
  logic             empty;
  logic [2*OPW-1:0] head;
  logic [OPW-1:0]   cnt;
  logic             zero_pair;

  assign in_ready = !full;

  mul_operand_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

`ifdef MUL_FEEDER_ZERO_BYPASS_EN
  assign zero_pair = has_zero_operand(head);
`else
  assign zero_pair = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (!empty) state_nxt = zero_pair ? ST_OUT : ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_CAPT;
      ST_CAPT: state_nxt = ST_OUT;
      ST_OUT:  if (out_valid && out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = (state == ST_IDLE) && !empty;
    mul_load = (state == ST_RUN);
  end

  // A bypassed pair enters OUT with out_valid low; OUT raises it one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            mul_a <= head[2*OPW-1:OPW];
            mul_b <= head[OPW-1:0];
            if (zero_pair) begin
              out_data <= '0;
            end
          end
        end
        ST_LOAD: cnt <= mul_b;
        ST_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - OPW'(1);
          end
        end
        ST_CAPT: begin
          out_data  <= mul_result;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_feeder.sv
// tb/tb_mul_feeder.sv - directed and random checks of mul_feeder against an iterative multiplier model
module tb_mul_feeder;

  localparam int FD = 4;
`ifdef MUL_FEEDER_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_a;
  logic [7:0]        in_b;
  logic              in_ready;
  logic              mul_load;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_result;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready;
  logic [$clog2(FD):0] fifo_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          produced = 0;
  logic [15:0] exp_q[$];
  bit          hold_prev = 1'b0;
  logic [15:0] hold_data = '0;

  always #5 clk = ~clk;

  mul_feeder #(.FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .mul_load   (mul_load),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  // Iterative multiplier: load on mul_load=0, add a once per iterate edge while b remains
  logic [15:0] m_acc;
  logic [7:0]  m_left;
  always @(posedge clk) begin
    if (!mul_load) begin
      m_acc  <= '0;
      m_left <= mul_b;
    end else if (m_left != 0) begin
      m_acc  <= m_acc + 16'(mul_a);
      m_left <= m_left - 8'd1;
    end
  end
  assign mul_result = m_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pair through an otherwise idle DUT; called and returns at a negedge
  task automatic do_single(input logic [7:0] a, input logic [7:0] b, input int hold);
    bit          byp = BYP && (a == 0 || b == 0);
    int          ones = 0;
    int          first_one = -1;
    int          lat = -1;
    logic [15:0] held;
    in_valid = 1'b1; in_a = a; in_b = b;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("count_after_push", fifo_count, 1);
    @(posedge clk); @(negedge clk);
    check("count_after_pop", fifo_count, 0);
    check("mul_a_loaded", mul_a, a);
    check("mul_b_loaded", mul_b, b);
    check("load_low_after_pop", mul_load, 0);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (mul_load) begin
        ones++;
        if (first_one < 0) first_one = k;
      end
    end
    check("out_latency", lat, byp ? 1 : b + 3);
    check("iterate_cycles", ones, byp ? 0 : b + 1);
    if (!byp) check("load_one_cycle", first_one, 1);
    check("product", out_data, 32'(a) * 32'(b));
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held);
      check("hold_mul_b", mul_b, b);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("valid_cleared", out_valid, 0);
    check("idle_load_low", mul_load, 0);
  endtask

  // One streaming cycle with a scoreboard of products in acceptance order
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, output logic acc);
    in_valid = v; in_a = a; in_b = b; out_ready = ordy;
    #1;
    if (hold_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, hold_data);
    end
    check("count_bound", fifo_count <= FD, 1);
    acc = v && in_ready;
    if (acc) exp_q.push_back(16'(32'(a) * 32'(b)));
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        check("stream_data", out_data, exp_q.pop_front());
        produced++;
      end
    end
    hold_prev = out_valid && !ordy;
    hold_data = out_data;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int          i;
    int          guard;
    int          sent;
    logic        acc;
    logic [7:0]  fa [6];
    logic [7:0]  fb [6];
    logic [7:0]  ra;
    logic [7:0]  rb;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_mul_load", mul_load, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_single(8'd3, 8'd4, 10);
    do_single(8'd255, 8'd255, 0);
    do_single(8'd7, 8'd0, 0);
    do_single(8'd0, 8'd9, 0);

    // Reset in the middle of a long RUN with another pair queued
    step(1'b1, 8'd9, 8'd200, 1'b0, acc);
    step(1'b1, 8'd5, 8'd5, 1'b0, acc);
    for (int k = 0; k < 50; k++) step(1'b0, 8'd0, 8'd0, 1'b0, acc);
    check("mid_run_iterating", mul_load, 1);
    check("mid_run_queued", fifo_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mul_load", mul_load, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_count", fifo_count, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_mul_b", mul_b, 0);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step(1'b0, 8'd0, 8'd0, 1'b1, acc);
    out_ready = 1'b0;
    do_single(8'd2, 8'd3, 0);

    // Fill the FIFO behind a stalled output, then drain in order
    for (int k = 0; k < 6; k++) begin
      fa[k] = 8'(k + 1);
      fb[k] = 8'(k + 2);
    end
    produced = 0;
    i = 0; guard = 0;
    while (i < 5 && guard < 100) begin
      step(1'b1, fa[i], fb[i], 1'b0, acc);
      if (acc) i++;
      guard++;
    end
    check("fill_accepted", i, 5);
    check("full_in_ready", in_ready, 0);
    check("full_count", fifo_count, FD);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, fa[5], fb[5], 1'b0, acc);
      check("full_blocked", acc, 0);
    end
    guard = 0;
    while (guard < 2000 && !(i == 6 && exp_q.size() == 0 && !out_valid)) begin
      step(i < 6, fa[i < 6 ? i : 0], fb[i < 6 ? i : 0], 1'b1, acc);
      if (acc) i++;
      guard++;
    end
    check("fifo_all_out", produced, 6);
    check("fifo_none_left", exp_q.size(), 0);

    // Random traffic with random back-pressure
    produced = 0; sent = 0; guard = 0;
    while (guard < 8000 && !(sent == 16 && exp_q.size() == 0 && !out_valid && fifo_count == 0)) begin
      ra = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      step((sent < 16) && ($urandom_range(0, 1) == 1), ra, rb, $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      guard++;
    end
    check("rand_all_out", produced, 16);
    check("rand_none_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
